// File: rtl/bus_master.sv
// Bus initiator: turns single-word core commands into one request/ready
// transaction on the shared tri-state bus, with a bounded wait for the slave.
module bus_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic [31:0] address,
  inout  wire  [31:0] data,
  output logic        request,
  output logic        r_w,
  input  logic        ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             data_oe_r;
  logic [31:0]      wdata_r;

  // Drivers are only ever enabled by a register, so the bus never glitches.
  assign data = data_oe_r ? wdata_r : {32{1'bz}};

  // Transaction sequencer: accept in IDLE, wait for ready or timeout, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      data_oe_r <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      request   <= 1'b0;
      r_w       <= 1'b1;
      address   <= 32'h0000_0000;
      cpu_rdata <= 32'h0000_0000;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_req) begin
            request   <= 1'b1;
            address   <= cpu_addr;
            r_w       <= cpu_rw;
            wdata_r   <= cpu_wdata;
            data_oe_r <= ~cpu_rw;
            cpu_busy  <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            state_r   <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // ready is checked first so a reply on the expiry edge still succeeds.
          if (ready == 1'b1) begin
            request   <= 1'b0;
            data_oe_r <= 1'b0;
            if (r_w) begin
              cpu_rdata <= data;
            end else begin
              cpu_rdata <= cpu_rdata;
            end
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b0;
            state_r   <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            request   <= 1'b0;
            data_oe_r <= 1'b0;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_ACCESS;
          end
        end
        ST_DONE: begin
          cpu_done <= 1'b0;
          cpu_err  <= 1'b0;
          cpu_busy <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          request   <= 1'b0;
          data_oe_r <= 1'b0;
          cpu_done  <= 1'b0;
          cpu_err   <= 1'b0;
          cpu_busy  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Self-checking bench for bus_master: directed scenarios plus randomized
// transactions scored against a latency/result model derived from the bus rules.
module tb_bus_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        cpu_done, cpu_err, cpu_busy;
  logic [31:0] address;
  wire  [31:0] data;
  logic        request, r_w;
  logic        ready = 1'b0;

  logic        slave_oe = 1'b0;
  logic [31:0] slave_val = 32'h0;
  assign data = slave_oe ? slave_val : {32{1'bz}};

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  bus_master #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_busy(cpu_busy),
    .address(address), .data(data), .request(request), .r_w(r_w), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction; the slave raises ready after `delay` wait cycles.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input int delay, input logic [31:0] sval);
    logic exp_err;
    int   exp_edges;
    int   edges;
    logic got;
    exp_err   = (delay >= TMO);
    exp_edges = exp_err ? TMO : delay + 1;
    edges = 0;
    got   = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wdata;
    ready = 1'b0; slave_oe = 1'b0;
    @(posedge clk); #1;
    // Scramble command inputs while busy; the latched transaction must not change.
    cpu_rw = ~rw; cpu_addr = ~addr; cpu_wdata = ~wdata;
    chk("accept_req", {31'd0, request}, 32'd1);
    chk("accept_addr", address, addr);
    chk("accept_rw", {31'd0, r_w}, {31'd0, rw});
    chk("accept_busy", {31'd0, cpu_busy}, 32'd1);
    for (int k = 0; k < TMO + 4 && !got; k++) begin
      @(negedge clk);
      ready = (k == delay);
      slave_oe = ready && rw;
      slave_val = sval;
      chk("hold_req", {31'd0, request}, 32'd1);
      chk("hold_addr", address, addr);
      chk("hold_rw", {31'd0, r_w}, {31'd0, rw});
      if (!rw) chk("write_data", data, wdata);
      @(posedge clk); #1;
      edges++;
      if (cpu_done) got = 1'b1;
    end
    if (rw && !exp_err) exp_rdata = sval;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("latency", 32'(edges), 32'(exp_edges));
    chk("err_flag", {31'd0, cpu_err}, {31'd0, exp_err});
    chk("rdata", cpu_rdata, exp_rdata);
    chk("req_released", {31'd0, request}, 32'd0);
    chk("busy_at_done", {31'd0, cpu_busy}, 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    ready = 1'b0; slave_oe = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse_end", {31'd0, cpu_done}, 32'd0);
    chk("err_pulse_end", {31'd0, cpu_err}, 32'd0);
    chk("busy_cleared", {31'd0, cpu_busy}, 32'd0);
    chk("rw_kept", {31'd0, r_w}, {31'd0, rw});
  endtask

  initial begin
    int starts;
    int last_start;
    logic prev_req;
    logic [31:0] presented;
    logic [31:0] cur_addr;

    // Reset values
    #12;
    chk("rst_req", {31'd0, request}, 32'd0);
    chk("rst_rw", {31'd0, r_w}, 32'd1);
    chk("rst_addr", address, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_err", {31'd0, cpu_err}, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Timer port read, ready on first request cycle
    run_txn(1'b1, 32'h03FF_FFFC, 32'h0, 0, 32'd35);
    // Write with three wait cycles
    run_txn(1'b0, 32'h0000_0100, 32'hA5A5_0001, 3, 32'h0);
    // Unmapped read times out, rdata keeps 35
    run_txn(1'b1, 32'h1234_0000, 32'h0, 1000, 32'hDEAD_BEEF);
    // Ready exactly on the expiry edge counts as success
    run_txn(1'b1, 32'h0000_0200, 32'h0, TMO - 1, 32'h0BAD_F00D);

    // Back-to-back: cpu_req held high, zero-wait slave, alternating addresses
    starts = 0; last_start = 0; prev_req = 1'b0; cur_addr = 32'h0;
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_wdata = 32'h1111_2222;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ready = request;
      presented = c[0] ? 32'h0000_0AA0 : 32'h0000_0550;
      cpu_addr = presented;
      @(posedge clk); #1;
      if (request && !prev_req) begin
        starts++;
        cur_addr = presented;
        chk("b2b_addr", address, presented);
        if (starts > 1) chk("b2b_period", 32'(c - last_start), 32'd3);
        last_start = c;
      end else if (request) begin
        chk("b2b_addr_stable", address, cur_addr);
      end
      prev_req = request;
    end
    chk("b2b_count", 32'(starts), 32'd4);
    cpu_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ready = request;
    end
    @(negedge clk);
    ready = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle", {31'd0, cpu_busy}, 32'd0);

    // Reset in the middle of a write access
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h0000_0300; cpu_wdata = 32'h7777_8888;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, request}, 32'd0);
    chk("arst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("arst_rw", {31'd0, r_w}, 32'd1);
    exp_rdata = 32'h0;
    chk("arst_rdata", cpu_rdata, exp_rdata);
    @(posedge clk); #1;
    chk("arst_no_done", {31'd0, cpu_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_still_idle", {31'd0, request}, 32'd0);
    run_txn(1'b0, 32'h0000_0300, 32'h7777_8888, 1, 32'h0);
    run_txn(1'b1, 32'h0000_0304, 32'h0, 2, 32'h4242_4242);

    // Randomized transactions against the model
    for (int i = 0; i < 16; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom,
              int'($urandom_range(0, TMO + 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
